// File: rtl/adc_pkg.sv
// Shared ADC constants, decimator defaults and the offset-binary to
// two's-complement conversion used by the decimator and the ADC controller bench.
package adc_pkg;

  localparam int ADC_WIDTH = 12;
  localparam logic [ADC_WIDTH-1:0] ADC_MIDSCALE = 12'h800;

  localparam int SAMPLE_DIV_DEF = 128;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int DEPTH_LOG2_DEF = 4;

  // Flipping the MSB of an offset-binary code is the same as subtracting midscale.
  function automatic logic signed [ADC_WIDTH-1:0] adc_to_signed(
    input logic [ADC_WIDTH-1:0] code
  );
    return signed'(code ^ ADC_MIDSCALE);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO: the head word is always on rd_data and a pop
// just advances the read pointer. A push while full is accepted only with a pop.
module sample_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [FILL_W-1:0]     fill_nxt;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    fill_nxt = fill;
    if (do_push && !do_pop) begin
      fill_nxt = fill + FILL_W'(1);
    end else if (do_pop && !do_push) begin
      fill_nxt = fill - FILL_W'(1);
    end
  end

  // Flags are registered from the next occupancy so they line up with fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      fill  <= fill_nxt;
      full  <= (fill_nxt == FILL_MAX);
      empty <= (fill_nxt == '0);
    end
  end

endmodule

// File: rtl/adc_sample_decimator.sv
// Samples the strobe-less ADC bus on a programmable tick, boxcar-averages
// 2^AVG_LOG2 signed samples and queues the results in a FWFT FIFO.
module adc_sample_decimator
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [11:0]           adc_val,
  output logic [11:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

  // Arithmetic shift floors toward minus infinity; the window sum cannot
  // exceed the sample range after the divide, so no saturation is needed.
  function automatic logic signed [ADC_WIDTH-1:0] avg_trunc(
    input logic signed [ACC_W-1:0] sum
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> AVG_LOG2;
    return signed'(shifted[ADC_WIDTH-1:0]);
  endfunction

  logic [TICK_W-1:0]             tick_cnt;
  logic [SMP_W-1:0]              smp_cnt;
  logic                          tick;
  logic                          win_end;
  logic signed [ADC_WIDTH-1:0]   smp_p0;
  logic signed [ACC_W-1:0]       acc_p0;
  logic signed [ACC_W-1:0]       sum_p0;
  logic signed [ADC_WIDTH-1:0]   avg_p1;
  logic                          vld_p1;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          drop;

  assign tick    = en && (tick_cnt == TICK_LAST);
  assign win_end = tick && (smp_cnt == SMP_LAST);
  assign smp_p0  = adc_to_signed(adc_val);
  assign sum_p0  = acc_p0 + ACC_W'(smp_p0);

  // Stage p0: tick timing and window accumulation; en low discards the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      smp_cnt  <= '0;
      acc_p0   <= '0;
    end else if (!en) begin
      tick_cnt <= '0;
      smp_cnt  <= '0;
      acc_p0   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (win_end) begin
        smp_cnt <= '0;
        acc_p0  <= '0;
      end else if (tick) begin
        smp_cnt <= smp_cnt + SMP_W'(1);
        acc_p0  <= sum_p0;
      end
    end
  end

  // Stage p1: averaged word waiting to be pushed; independent of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      avg_p1 <= '0;
    end else begin
      vld_p1 <= win_end;
      if (win_end) begin
        avg_p1 <= avg_trunc(sum_p0);
      end
    end
  end

  sample_fifo #(
    .WIDTH      (ADC_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (avg_p1),
    .pop       (out_ready),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign out_valid = !fifo_empty;
  // A full FIFO still takes the word if the consumer frees a slot this cycle.
  assign drop      = vld_p1 && fifo_full && !out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Directed bench for adc_sample_decimator at default parameters
// (128-clock tick, 4-sample average, 16-entry FIFO).
module tb_adc_sample_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] adc_val = 12'h000;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fill;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  adc_sample_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .adc_val   (adc_val),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run one 4-tick window from a cleared state; returns in cycle 513 with en low.
  task automatic run_window(input logic [11:0] a0, input logic [11:0] a1,
                            input logic [11:0] a2, input logic [11:0] a3);
    en = 1'b1;
    adc_val = a0; cyc(128);
    adc_val = a1; cyc(128);
    adc_val = a2; cyc(128);
    adc_val = a3; cyc(128);
    cyc(1);
    en = 1'b0;
  endtask

  task automatic test_reset;
    cyc(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_vec++; if (fill !== 5'd0) begin n_err++; $display("FAIL rst_fill: got %0d expected 0", fill); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL rst_data: got %h expected 000", out_data); end
    rst = 1'b1;
    cyc(600);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    adc_val = 12'hFFF;
    en = 1'b1;
    cyc(512);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b expected 0", out_valid); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 12'h7FF) begin n_err++; $display("FAIL basic_data: got %h expected 7ff", out_data); end
    n_vec++; if (fill !== 5'd1) begin n_err++; $display("FAIL basic_fill: got %0d expected 1", fill); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_popped: got %b expected 0", out_valid); end
    cyc(510);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early2: got %b expected 0", out_valid); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid2: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 12'h7FF) begin n_err++; $display("FAIL basic_data2: got %h expected 7ff", out_data); end
    en = 1'b0;
    cyc(2);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_average;
    out_ready = 1'b1;
    run_window(12'h800, 12'h900, 12'h800, 12'h900);
    n_vec++; if (out_data !== 12'h080 || out_valid !== 1'b1) begin n_err++; $display("FAIL avg_alt: got %h/%b expected 080/1", out_data, out_valid); end
    cyc(1);
    run_window(12'h000, 12'h000, 12'h000, 12'h000);
    n_vec++; if (out_data !== 12'h800 || out_valid !== 1'b1) begin n_err++; $display("FAIL avg_min: got %h/%b expected 800/1", out_data, out_valid); end
    cyc(1);
    run_window(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE);
    n_vec++; if (out_data !== 12'h7FE || out_valid !== 1'b1) begin n_err++; $display("FAIL avg_floor_pos: got %h/%b expected 7fe/1", out_data, out_valid); end
    cyc(1);
    run_window(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FE);
    n_vec++; if (out_data !== 12'hFFE || out_valid !== 1'b1) begin n_err++; $display("FAIL avg_floor_neg: got %h/%b expected ffe/1", out_data, out_valid); end
    cyc(1);
  endtask

  task automatic test_overflow;
    logic [11:0] exp_w;
    out_ready = 1'b0;
    en = 1'b1;
    for (int w = 0; w < 17; w++) begin
      adc_val = 12'h800 + 12'(w * 16);
      cyc(512);
    end
    n_vec++; if (fill !== 5'd16) begin n_err++; $display("FAIL ovf_fill_pre: got %0d expected 16", fill); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
    cyc(1);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_vec++; if (fill !== 5'd16) begin n_err++; $display("FAIL ovf_fill: got %0d expected 16", fill); end
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_w = 12'(i * 16);
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL drain_%0d: got %h/%b expected %h/1", i, out_data, out_valid, exp_w); end
      cyc(1);
    end
    n_vec++; if (out_valid !== 1'b0 || fill !== 5'd0) begin n_err++; $display("FAIL drain_empty: got %b/%0d expected 0/0", out_valid, fill); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    out_ready = 1'b0;
    en = 1'b1;
    for (int w = 0; w < 17; w++) begin
      adc_val = 12'h800 + 12'(w * 16);
      cyc(512);
    end
    // Cycle 8704: window 16 in the push stage while full; pop in the same cycle.
    out_ready = 1'b1;
    adc_val = 12'h910;
    cyc(1);
    out_ready = 1'b0;
    n_vec++; if (fill !== 5'd16) begin n_err++; $display("FAIL full_pp_fill: got %0d expected 16", fill); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf: got %b expected 0", overflow); end
    n_vec++; if (out_data !== 12'h010) begin n_err++; $display("FAIL full_pp_head: got %h expected 010", out_data); end
    cyc(511);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b expected 1", overflow); end
    n_vec++; if (fill !== 5'd16) begin n_err++; $display("FAIL drop_fill: got %0d expected 16", fill); end
    en = 1'b0;
    out_ready = 1'b1;
    cyc(15);
    n_vec++; if (out_data !== 12'h100 || fill !== 5'd1) begin n_err++; $display("FAIL full_last: got %h/%0d expected 100/1", out_data, fill); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_en_gap;
    out_ready = 1'b0;
    en = 1'b1;
    adc_val = 12'hFFF;
    cyc(512);
    adc_val = 12'h000;
    cyc(256);
    en = 1'b0;
    cyc(50);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h7FF || fill !== 5'd1) begin n_err++; $display("FAIL idle_hold: got %b/%h/%0d expected 1/7ff/1", out_valid, out_data, fill); end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_pop: got %b expected 0", out_valid); end
    en = 1'b1;
    adc_val = 12'h900;
    cyc(512);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early: got %b expected 0", out_valid); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h100) begin n_err++; $display("FAIL gap_fresh: got %b/%h expected 1/100", out_valid, out_data); end
    en = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    en = 1'b1;
    adc_val = 12'hFFF;
    cyc(2760);
    n_vec++; if (fill !== 5'd5 || out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %0d/%b expected 5/1", fill, out_valid); end
    n_vec++; if (overflow !== 1'b1 || out_data !== 12'h7FF) begin n_err++; $display("FAIL ar_pre_ovf: got %b/%h expected 1/7ff", overflow, out_data); end
    rst = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    n_vec++; if (fill !== 5'd0) begin n_err++; $display("FAIL ar_fill: got %0d expected 0", fill); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ar_ovf: got %b expected 0", overflow); end
    n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL ar_data: got %h expected 000", out_data); end
    rst = 1'b1;
    adc_val = 12'h700;
    cyc(512);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_early: got %b expected 0", out_valid); end
    cyc(1);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'hF00 || fill !== 5'd1) begin n_err++; $display("FAIL ar_resume: got %b/%h/%0d expected 1/f00/1", out_valid, out_data, fill); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_overflow();
    test_full_push_pop();
    test_en_gap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
